// File: rtl/mips_pipe_pkg.sv
// Shared EXE/MEM pipeline definitions: memory command encodings and the
// default-width payload carried between the two stages.
package mips_pipe_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_PC_W   = 32;
    localparam int unsigned DEF_REG_W  = 5;
    localparam int unsigned DEF_CMD_W  = 2;

    localparam logic [1:0] MEM_CMD_NONE  = 2'b00;
    localparam logic [1:0] MEM_CMD_READ  = 2'b01;
    localparam logic [1:0] MEM_CMD_WRITE = 2'b10;

    typedef struct packed {
        logic                  wb_en;
        logic [DEF_CMD_W-1:0]  mem_cmd;
        logic [DEF_DATA_W-1:0] alu_res;
        logic [DEF_DATA_W-1:0] src2_val;
        logic [DEF_REG_W-1:0]  dst;
        logic [DEF_PC_W-1:0]   pc;
    } exe_mem_payload_t;

endpackage

// File: rtl/exe_mem_elastic_reg_if.sv
// EXE-side and MEM-side handshake plus payload for the EXE/MEM elastic register.
interface exe_mem_elastic_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CMD_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic              WB_EN_EXE;
    logic [CMD_W-1:0]  MEM_CMD_EXE;
    logic [DATA_W-1:0] ALU_res_EXE;
    logic [DATA_W-1:0] src2_val_EXE;
    logic [REG_W-1:0]  Dst_EXE;
    logic [PC_W-1:0]   PC_in;

    logic              out_valid;
    logic              out_ready;
    logic              WB_EN_MEM;
    logic [CMD_W-1:0]  MEM_CMD_MEM;
    logic [DATA_W-1:0] ALU_res_MEM;
    logic [DATA_W-1:0] src2_val_MEM;
    logic [REG_W-1:0]  Dst_MEM;
    logic [PC_W-1:0]   PC;

    modport master (
        output in_valid, WB_EN_EXE, MEM_CMD_EXE, ALU_res_EXE, src2_val_EXE, Dst_EXE, PC_in,
        output out_ready,
        input  in_ready, out_valid,
        input  WB_EN_MEM, MEM_CMD_MEM, ALU_res_MEM, src2_val_MEM, Dst_MEM, PC
    );

    modport slave (
        input  in_valid, WB_EN_EXE, MEM_CMD_EXE, ALU_res_EXE, src2_val_EXE, Dst_EXE, PC_in,
        input  out_ready,
        output in_ready, out_valid,
        output WB_EN_MEM, MEM_CMD_MEM, ALU_res_MEM, src2_val_MEM, Dst_MEM, PC
    );
endinterface

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus payload register. Clear drops only the
// valid bit so a killed slot still shows its last payload.
module pipe_slot
    import mips_pipe_pkg::*;
#(
    parameter type T = exe_mem_payload_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clear,
    input  T     i_data,
    output logic o_valid,
    output T     o_data
);
    logic r_valid;
    T     r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/exe_mem_elastic_reg.sv
// EXE/MEM pipeline register with a skid slot so in_ready is a pure register
// output; outputs always come from the main slot.
module exe_mem_elastic_reg
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CMD_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    exe_mem_elastic_reg_if.slave bus,
    output logic [1:0]           occupancy,
    output logic [1:0]           hz_wb_en,
    output logic [2*REG_W-1:0]   hz_dst
);
    typedef struct packed {
        logic              wb_en;
        logic [CMD_W-1:0]  mem_cmd;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] src2_val;
        logic [REG_W-1:0]  dst;
        logic [PC_W-1:0]   pc;
    } payload_t;

    payload_t w_in_d;
    payload_t w_main_d;
    payload_t w_main_q;
    payload_t w_skid_q;
    logic     w_main_valid;
    logic     w_skid_valid;
    logic     w_in_fire;
    logic     w_out_fire;
    logic     w_main_from_skid;
    logic     w_main_from_in;
    logic     w_main_load;
    logic     w_main_clear;
    logic     w_skid_load;
    logic     w_skid_clear;

    assign w_in_d = '{wb_en:    bus.WB_EN_EXE,
                      mem_cmd:  bus.MEM_CMD_EXE,
                      alu_res:  bus.ALU_res_EXE,
                      src2_val: bus.src2_val_EXE,
                      dst:      bus.Dst_EXE,
                      pc:       bus.PC_in};

    // Flush suppresses every load so killed slots keep their old payload.
    assign w_in_fire        = bus.in_valid && !w_skid_valid && !flush;
    assign w_out_fire       = w_main_valid && bus.out_ready;
    assign w_main_from_skid = w_skid_valid && w_out_fire && !flush;
    assign w_main_from_in   = w_in_fire && (!w_main_valid || w_out_fire);
    assign w_main_load      = w_main_from_skid || w_main_from_in;
    assign w_main_clear     = flush || (w_out_fire && !w_main_load);
    assign w_main_d         = w_main_from_skid ? w_skid_q : w_in_d;
    assign w_skid_load      = w_in_fire && w_main_valid && !w_out_fire;
    assign w_skid_clear     = flush || w_main_from_skid;

    pipe_slot #(.T(payload_t)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_valid),
        .o_data  (w_main_q)
    );

    pipe_slot #(.T(payload_t)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_d),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_q)
    );

    // Bubbles never write back or issue a memory command.
    assign bus.in_ready     = !w_skid_valid;
    assign bus.out_valid    = w_main_valid;
    assign bus.WB_EN_MEM    = w_main_q.wb_en && w_main_valid;
    assign bus.MEM_CMD_MEM  = w_main_valid ? w_main_q.mem_cmd : CMD_W'(MEM_CMD_NONE);
    assign bus.ALU_res_MEM  = w_main_q.alu_res;
    assign bus.src2_val_MEM = w_main_q.src2_val;
    assign bus.Dst_MEM      = w_main_q.dst;
    assign bus.PC           = w_main_q.pc;

    assign occupancy = 2'(w_main_valid) + 2'(w_skid_valid);
    assign hz_wb_en  = {w_skid_q.wb_en && w_skid_valid, w_main_q.wb_en && w_main_valid};
    assign hz_dst    = {w_skid_q.dst, w_main_q.dst};
endmodule

// File: tb/tb_exe_mem_elastic_reg.sv
// Directed bench for exe_mem_elastic_reg: default-width instance plus a
// 64-bit data / 6-bit register-index instance.
module tb_exe_mem_elastic_reg;
    import mips_pipe_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       flush2;
    logic [1:0] occupancy;
    logic [1:0] hz_wb_en;
    logic [9:0] hz_dst;
    logic [1:0] occupancy2;
    logic [1:0] hz_wb_en2;
    logic [11:0] hz_dst2;

    int errors = 0;
    int checks = 0;

    exe_mem_elastic_reg_if bus ();
    exe_mem_elastic_reg_if #(.DATA_W(64), .REG_W(6)) bus2 ();

    exe_mem_elastic_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .hz_wb_en  (hz_wb_en),
        .hz_dst    (hz_dst)
    );

    exe_mem_elastic_reg #(.DATA_W(64), .REG_W(6)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush2),
        .bus       (bus2),
        .occupancy (occupancy2),
        .hz_wb_en  (hz_wb_en2),
        .hz_dst    (hz_dst2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic v, input logic [31:0] alu, input logic [4:0] dst);
        bus.in_valid     = v;
        bus.WB_EN_EXE    = 1'b1;
        bus.MEM_CMD_EXE  = MEM_CMD_WRITE;
        bus.ALU_res_EXE  = alu;
        bus.src2_val_EXE = ~alu;
        bus.Dst_EXE      = dst;
        bus.PC_in        = alu << 2;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".wb_en"},  64'(bus.WB_EN_MEM),    64'd0);
        chk({tag, ".cmd"},    64'(bus.MEM_CMD_MEM),  64'd0);
        chk({tag, ".alu"},    64'(bus.ALU_res_MEM),  64'd0);
        chk({tag, ".src2"},   64'(bus.src2_val_MEM), 64'd0);
        chk({tag, ".dst"},    64'(bus.Dst_MEM),      64'd0);
        chk({tag, ".pc"},     64'(bus.PC),           64'd0);
        chk({tag, ".occ"},    64'(occupancy),        64'd0);
        chk({tag, ".in_rdy"}, 64'(bus.in_ready),     64'd1);
        chk({tag, ".o_vld"},  64'(bus.out_valid),    64'd0);
        chk({tag, ".hz_wb"},  64'(hz_wb_en),         64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b1;
        flush2 = 1'b0;
        send(1'b1, 32'hDEAD_BEEF, 5'd31);
        bus.MEM_CMD_EXE = MEM_CMD_READ;
        bus.out_ready   = 1'b0;
        bus2.in_valid     = 1'b0;
        bus2.WB_EN_EXE    = 1'b0;
        bus2.MEM_CMD_EXE  = MEM_CMD_NONE;
        bus2.ALU_res_EXE  = '0;
        bus2.src2_val_EXE = '0;
        bus2.Dst_EXE      = '0;
        bus2.PC_in        = '0;
        bus2.out_ready    = 1'b1;

        // Reset with garbage inputs
        tick();
        tick();
        chk_reset_state("reset");
        chk("reset.occ2", 64'(occupancy2), 64'd0);
        rst   = 1'b0;
        flush = 1'b0;
        send(1'b0, 32'd0, 5'd0);

        // Streaming: 1..8 back to back, consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(1'b1, 32'(i), 5'(i));
            bus.MEM_CMD_EXE = MEM_CMD_READ;
            chk("stream.in_rdy", 64'(bus.in_ready), 64'd1);
            tick();
            chk("stream.o_vld", 64'(bus.out_valid),   64'd1);
            chk("stream.alu",   64'(bus.ALU_res_MEM), 64'(i));
            chk("stream.pc",    64'(bus.PC),          64'(4 * i));
            chk("stream.cmd",   64'(bus.MEM_CMD_MEM), 64'(MEM_CMD_READ));
            chk("stream.occ",   64'(occupancy),       64'd1);
        end
        send(1'b0, 32'd0, 5'd0);
        tick();
        chk("drain.o_vld", 64'(bus.out_valid),   64'd0);
        chk("drain.occ",   64'(occupancy),       64'd0);
        chk("drain.wb",    64'(bus.WB_EN_MEM),   64'd0);
        chk("drain.cmd",   64'(bus.MEM_CMD_MEM), 64'(MEM_CMD_NONE));
        chk("drain.hold",  64'(bus.ALU_res_MEM), 64'd8);

        // Backpressure: A, B fill both slots, C held by source
        bus.out_ready = 1'b0;
        send(1'b1, 32'hA, 5'd10);
        tick();
        chk("bp.a.occ",    64'(occupancy),     64'd1);
        chk("bp.a.in_rdy", 64'(bus.in_ready),  64'd1);
        send(1'b1, 32'hB, 5'd11);
        tick();
        chk("bp.b.occ",    64'(occupancy),       64'd2);
        chk("bp.b.in_rdy", 64'(bus.in_ready),    64'd0);
        chk("bp.b.alu",    64'(bus.ALU_res_MEM), 64'hA);
        send(1'b1, 32'hC, 5'd12);
        tick();
        chk("bp.c.occ",    64'(occupancy),       64'd2);
        chk("bp.c.alu",    64'(bus.ALU_res_MEM), 64'hA);
        chk("bp.c.hz_wb",  64'(hz_wb_en),        64'd3);
        chk("bp.c.hz_dst", 64'(hz_dst),          64'({5'd11, 5'd10}));
        bus.out_ready = 1'b1;
        tick();
        chk("bp.rel1.alu",    64'(bus.ALU_res_MEM), 64'hB);
        chk("bp.rel1.occ",    64'(occupancy),       64'd1);
        chk("bp.rel1.in_rdy", 64'(bus.in_ready),    64'd1);
        tick();
        chk("bp.rel2.alu",    64'(bus.ALU_res_MEM), 64'hC);
        chk("bp.rel2.dst",    64'(bus.Dst_MEM),     64'd12);
        chk("bp.rel2.occ",    64'(occupancy),       64'd1);
        send(1'b0, 32'd0, 5'd0);
        tick();
        chk("bp.end.occ", 64'(occupancy), 64'd0);

        // Flush with both slots full and a live input
        bus.out_ready = 1'b0;
        send(1'b1, 32'h11, 5'd1);
        tick();
        send(1'b1, 32'h22, 5'd2);
        tick();
        chk("fl.pre.occ", 64'(occupancy), 64'd2);
        send(1'b1, 32'h33, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl.occ",    64'(occupancy),       64'd0);
        chk("fl.wb",     64'(bus.WB_EN_MEM),   64'd0);
        chk("fl.cmd",    64'(bus.MEM_CMD_MEM), 64'(MEM_CMD_NONE));
        chk("fl.hz_wb",  64'(hz_wb_en),        64'd0);
        chk("fl.in_rdy", 64'(bus.in_ready),    64'd1);
        chk("fl.hold",   64'(bus.ALU_res_MEM), 64'h11);
        send(1'b0, 32'd0, 5'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("fl.post.o_vld", 64'(bus.out_valid), 64'd0);
        chk("fl.post.occ",   64'(occupancy),     64'd0);

        // Reset and flush together while skid is full
        bus.out_ready = 1'b0;
        send(1'b1, 32'h44, 5'd4);
        tick();
        send(1'b1, 32'h55, 5'd5);
        tick();
        chk("prio.pre.occ", 64'(occupancy), 64'd2);
        send(1'b1, 32'h66, 5'd6);
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        chk_reset_state("prio");
        rst   = 1'b0;
        flush = 1'b0;
        send(1'b0, 32'd0, 5'd0);

        // Wide instance: full-width data and max register index pass intact
        for (int i = 0; i < 8; i++) begin
            bus2.in_valid     = 1'b1;
            bus2.WB_EN_EXE    = 1'b1;
            bus2.MEM_CMD_EXE  = MEM_CMD_READ;
            bus2.ALU_res_EXE  = 64'hFFFF_FFFF_FFFF_FFF8 + 64'(i);
            bus2.src2_val_EXE = 64'h8000_0000_0000_0000 | 64'(i);
            bus2.Dst_EXE      = 6'(63 - i);
            tick();
            chk("wide.alu",  64'(bus2.ALU_res_MEM),  64'hFFFF_FFFF_FFFF_FFF8 + 64'(i));
            chk("wide.src2", 64'(bus2.src2_val_MEM), 64'h8000_0000_0000_0000 | 64'(i));
            chk("wide.dst",  64'(bus2.Dst_MEM),      64'(63 - i));
            chk("wide.occ",  64'(occupancy2),        64'd1);
        end
        chk("wide.last", 64'(bus2.ALU_res_MEM), 64'hFFFF_FFFF_FFFF_FFFF);
        bus2.in_valid = 1'b0;
        tick();
        chk("wide.drain.occ", 64'(occupancy2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
